mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the single-cycle MIPS datapath, converting it to a FETCH/DECODE/EXEC/MEM/WB sequence.
- Decodes the latched instruction and drives every datapath control line, plus PC and IR write enables.
- Gates all architectural writes to exactly one cycle per instruction.
- Holds in MEM on a data-memory ready handshake.

Parameters:
- MEM_WAIT_MAX, 15: MEM cycles waited for mem_ready before `mem_timeout` pulses and the FSM returns to FETCH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word from the IFU.
- zero  in  1  ALU equality flag.
- mem_ready  in  1  data memory access done this cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  instruction register load.
- npcsel  out  2  next-PC select: 00 = PC+4, 01 = beq target if zero else PC+4, 10 = j/jal target, 11 = rs.
- RegDst  out  2  write-register select: 00 = rt, 01 = rd, 10 = $31.
- ALUSrc  out  1  ALU B operand: 0 = busB, 1 = extended immediate.
- MemtoReg  out  2  write-back source: 00 = ALU, 01 = DM, 10 = PC4.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  GRF write strobe.
- EXTop  out  2  immediate extend: 00 = zero-extend, 01 = sign-extend, 10 = imm<<16.
- ALUctr  out  2  ALU operation: 00 = add, 01 = sub, 10 = or.
- state  out  3  current FSM state (debug).
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct.
- mem_timeout  out  1  one-cycle pulse when the MEM wait is exhausted.

Behaviour:
- Reset (reset=0, async):
  - state=FETCH; wait counter=0.
  - pc_we, ir_we, MemWrite, RegWrite, illegal, mem_timeout all 0.
  - Mux selects all 0.
- Encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Outputs are Moore-decoded from the state and the latched instruction.
- Supported instructions:
  - R-type: addu (funct 0x21), subu (0x23), jr (0x08), nop (all-zero word).
  - I/J-type: ori (0x0D), lui (0x0F), lw (0x23), sw (0x2B), beq (0x04), j (0x02), jal (0x03).
- FETCH: ir_we=1 for 1 cycle; next state DECODE.
- DECODE: control is decoded from `instr`, which is stable after FETCH.
  - illegal or nop: pc_we=1, npcsel=00, illegal=1 if illegal; next state FETCH.
  - j: pc_we=1, npcsel=10; next state FETCH.
  - jr: pc_we=1, npcsel=11; next state FETCH.
  - jal: next state WB.
  - all others: next state EXEC.
- EXEC: ALUctr and ALUSrc are driven.
  - beq: ALUctr=01, ALUSrc=0, pc_we=1, npcsel=01; next state FETCH.
  - lw/sw: ALUctr=00, ALUSrc=1, EXTop=01; next state MEM.
  - R/ori/lui: next state WB.
- MEM: ALU controls are held.
  - sw: MemWrite=mem_ready.
  - On mem_ready: sw sets pc_we=1, npcsel=00, next state FETCH; lw goes to WB.
  - Otherwise the wait counter increments. When the counter reaches MEM_WAIT_MAX: mem_timeout=1, pc_we=1, npcsel=00, no write, next state FETCH.
  - The counter clears on MEM exit.
- WB: RegWrite=1, pc_we=1.
  - npcsel=10 for jal, else 00.
  - addu/subu: RegDst=01, MemtoReg=00, ALUctr=00/01.
  - ori: RegDst=00, EXTop=00, ALUSrc=1, ALUctr=10.
  - lui: RegDst=00, EXTop=10, ALUSrc=1, ALUctr=10 ($0 | imm<<16).
  - lw: RegDst=00, MemtoReg=01.
  - jal: RegDst=10, MemtoReg=10.
- Latencies (cycles): j/jr/nop/illegal 2; beq/jal 3; R/ori/lui 4; sw 4+wait; lw 5+wait.
- Invariants:
  - pc_we is high exactly once per instruction, always in the final cycle.
  - RegWrite and MemWrite are never high together.
  - Unused selects are driven to 0.
- Reset asserted mid-instruction aborts immediately with no write strobe.
- mem_ready outside MEM is ignored.

Optional Feature:
- MC_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[31:0] and ret_cnt[31:0], both reset to 0.
  - cyc_cnt increments every cycle.
  - ret_cnt increments on every pc_we cycle, including illegal and timeout cases.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode/funct constants;
  - npcsel, RegDst, MemtoReg, EXTop and ALUctr encodings;
  - an instruction-class type (RTYPE_ALU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, NOP, ILLEGAL).
- One combinational sub-module, mc_decode: instr -> instruction class. The FSM stays in mc_ctrl.

Test Plan:
- Reset low mid-EXEC of addu, then release → state=0, all write strobes 0; next cycle ir_we=1.
- addu $3,$1,$2 (0x00221821) → ir_we at cycle 0; RegWrite=1, RegDst=01, ALUctr=00, pc_we=1, npcsel=00 at cycle 3; 4 cycles total.
- lw with mem_ready low for 2 cycles → MEM lasts 3 cycles; WB has MemtoReg=01, RegWrite=1; 7 cycles total; MemWrite never 1.
- sw with mem_ready held low and MEM_WAIT_MAX=15 → mem_timeout pulse after 15 MEM cycles; pc_we=1, npcsel=00; MemWrite stays 0 throughout.
- beq with zero=1 then zero=0 → each takes 3 cycles, with pc_we=1 and npcsel=01 in EXEC.
- jal, jr, then opcode 0x3F → jal: WB with RegDst=10, MemtoReg=10, npcsel=10. jr: npcsel=11 in DECODE. 0x3F: illegal pulse, npcsel=00, no RegWrite.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle MIPS controller.
//   - FSM state encoding (also exported on the debug state port)
//   - opcode / funct constants for the supported instruction subset
//   - datapath select encodings (npcsel, RegDst, MemtoReg, EXTop, ALUctr)
//   - instruction-class type produced by mc_decode
//   - alu_ctl(): ALU operand/operation selects for a given instruction class
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BEQ  = 2'b01;
  localparam logic [1:0] NPC_JUMP = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;

  localparam logic [1:0] WBSRC_ALU = 2'b00;
  localparam logic [1:0] WBSRC_DM  = 2'b01;
  localparam logic [1:0] WBSRC_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  typedef enum logic [3:0] {
    RTYPE_ALU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, NOP, ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic [1:0] aluctr;
    logic       alusrc;
    logic [1:0] extop;
  } alu_ctl_t;

  function automatic alu_ctl_t alu_ctl(input iclass_t ic, input logic is_sub);
    alu_ctl_t c;
    c = '0;
    case (ic)
      RTYPE_ALU: c.aluctr = is_sub ? ALU_SUB : ALU_ADD;
      ORI:       begin c.aluctr = ALU_OR;  c.alusrc = 1'b1; c.extop = EXT_ZERO; end
      LUI:       begin c.aluctr = ALU_OR;  c.alusrc = 1'b1; c.extop = EXT_LUI;  end
      LW, SW:    begin c.aluctr = ALU_ADD; c.alusrc = 1'b1; c.extop = EXT_SIGN; end
      BEQ:       c.aluctr = ALU_SUB;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational instruction classifier.
//   instr  in  32  instruction word (stable from DECODE onward)
//   iclass out     instruction class; anything unsupported maps to ILLEGAL
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass
);

  logic [5:0] op;
  logic [5:0] fn;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    iclass = ILLEGAL;
    if (instr == 32'd0) begin
      iclass = NOP;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADDU, FN_SUBU: iclass = RTYPE_ALU;
            FN_JR:            iclass = JR;
            default:          iclass = ILLEGAL;
          endcase
        end
        OP_ORI:  iclass = ORI;
        OP_LUI:  iclass = LUI;
        OP_LW:   iclass = LW;
        OP_SW:   iclass = SW;
        OP_BEQ:  iclass = BEQ;
        OP_J:    iclass = J;
        OP_JAL:  iclass = JAL;
        default: iclass = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the MIPS datapath.
// Ports:
//   clk, reset (async, active low), instr[31:0], zero, mem_ready
//   pc_we, ir_we, npcsel[1:0], RegDst[1:0], ALUSrc, MemtoReg[1:0], MemWrite,
//   RegWrite, EXTop[1:0], ALUctr[1:0], state[2:0], illegal, mem_timeout
//   cyc_cnt[31:0], ret_cnt[31:0] only when MC_PERF_CNT_EN is defined.
// Parameter MEM_WAIT_MAX (>= 1): MEM cycles waited for mem_ready before timing out.
//
// state  | meaning
// FETCH  | load IR (ir_we)
// DECODE | classify; finish nop/illegal/j/jr
// EXEC   | ALU op; finish beq
// MEM    | wait for mem_ready; finish sw or time out
// WB     | register write; finish ALU ops, lw, jal
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic [1:0]  npcsel,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [1:0]  MemtoReg,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  EXTop,
  output logic [1:0]  ALUctr,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        mem_timeout
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t   st;
  logic [CW-1:0] wait_cnt;
  iclass_t  ic;
  logic     is_sub;
  logic     mem_expired;
  alu_ctl_t actl;

  // Branch resolution is done in the datapath (npcsel=01 uses zero there).
  logic unused_zero;
  assign unused_zero = zero;

  mc_decode u_decode (
    .instr  (instr),
    .iclass (ic)
  );

  assign is_sub      = (instr[5:0] == FN_SUBU);
  assign mem_expired = (wait_cnt == CW'(MEM_WAIT_MAX));
  assign actl        = alu_ctl(ic, is_sub);
  assign state       = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= FETCH;
      wait_cnt <= '0;
    end else begin
      case (st)
        FETCH:  st <= DECODE;
        DECODE: begin
          case (ic)
            NOP, ILLEGAL, J, JR: st <= FETCH;
            JAL:                 st <= WB;
            default:             st <= EXEC;
          endcase
        end
        EXEC: begin
          case (ic)
            LW, SW:              st <= MEM;
            RTYPE_ALU, ORI, LUI: st <= WB;
            default:             st <= FETCH;
          endcase
        end
        MEM: begin
          // mem_ready wins over an expiring counter in the same cycle
          if (mem_ready) begin
            wait_cnt <= '0;
            st       <= (ic == LW) ? WB : FETCH;
          end else if (mem_expired) begin
            wait_cnt <= '0;
            st       <= FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WB:      st <= FETCH;
        default: st <= FETCH;
      endcase
    end
  end

  // Moore decode of state + instruction; MemWrite/pc_we in MEM follow mem_ready
  // directly so the store strobe lands in the handshake cycle.
  always_comb begin
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    npcsel      = NPC_PC4;
    RegDst      = DST_RT;
    ALUSrc      = 1'b0;
    MemtoReg    = WBSRC_ALU;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    EXTop       = EXT_ZERO;
    ALUctr      = ALU_ADD;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    case (st)
      // gated by reset so nothing loads while reset is held
      FETCH: ir_we = reset;
      DECODE: begin
        case (ic)
          NOP:     pc_we = 1'b1;
          ILLEGAL: begin pc_we = 1'b1; illegal = 1'b1; end
          J:       begin pc_we = 1'b1; npcsel = NPC_JUMP; end
          JR:      begin pc_we = 1'b1; npcsel = NPC_RS; end
          default: ;
        endcase
      end
      EXEC: begin
        ALUctr = actl.aluctr;
        ALUSrc = actl.alusrc;
        EXTop  = actl.extop;
        if (ic == BEQ) begin
          pc_we  = 1'b1;
          npcsel = NPC_BEQ;
        end
      end
      MEM: begin
        ALUctr = actl.aluctr;
        ALUSrc = actl.alusrc;
        EXTop  = actl.extop;
        if (mem_ready) begin
          MemWrite = (ic == SW);
          pc_we    = (ic == SW);
        end else if (mem_expired) begin
          mem_timeout = 1'b1;
          pc_we       = 1'b1;
        end
      end
      WB: begin
        RegWrite = 1'b1;
        pc_we    = 1'b1;
        case (ic)
          RTYPE_ALU, ORI, LUI: begin
            ALUctr = actl.aluctr;
            ALUSrc = actl.alusrc;
            EXTop  = actl.extop;
            RegDst = (ic == RTYPE_ALU) ? DST_RD : DST_RT;
          end
          LW:  MemtoReg = WBSRC_DM;
          JAL: begin
            RegDst   = DST_RA;
            MemtoReg = WBSRC_PC4;
            npcsel   = NPC_JUMP;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (pc_we) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule
